// File: rtl/mem_sequencer.sv
// PDP-8 memory access sequencer. It latches CPU requests, forms field-extended
// addresses, performs auto-index read-modify-write, and holds the IF/DF/IB field registers.
module mem_sequencer #(
   parameter int AWIDTH = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic              dsel,
   input  logic              autoinc_en,
   input  logic [11:0]       addr,
   input  logic [11:0]       wdata,
   output logic              ack,
   output logic [11:0]       rdata,
   output logic              busy,
   input  logic [2:0]        field_in,
   input  logic              if_load,
   input  logic              df_load,
   input  logic              ib_load,
   input  logic              ib_xfer,
   output logic [2:0]        if_q,
   output logic [2:0]        df_q,
   output logic [2:0]        ib_q,
   output logic [AWIDTH-1:0] mem_raddr,
   output logic [AWIDTH-1:0] mem_waddr,
   output logic              mem_wren,
   output logic [11:0]       mem_wdata,
   input  logic [11:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, WR, RD, RDDONE} state_t;

   state_t            state;
   logic [AWIDTH-1:0] ea;
   logic [11:0]       wd;
   logic              ai;
   logic [14:0]       ea_full;
   logic [11:0]       rd_inc;

   // With AWIDTH < 15 the upper field bits fall away and the address wraps.
   assign ea_full = {dsel ? df_q : if_q, addr};
   assign rd_inc  = mem_rdata + 12'd1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ea    <= '0;
         wd    <= '0;
         ai    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  ea    <= ea_full[AWIDTH-1:0];
                  wd    <= wdata;
                  ai    <= autoinc_en & ~we & (addr[11:3] == 9'o001);
                  state <= we ? WR : RD;
               end
            end
            WR:      state <= IDLE;
            RD:      state <= RDDONE;
            RDDONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Field registers run independently of the sequencer; IF load outranks IB transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_q <= '0;
         df_q <= '0;
         ib_q <= '0;
      end else begin
         if (if_load)      if_q <= field_in;
         else if (ib_xfer) if_q <= ib_q;
         if (df_load)      df_q <= field_in;
         if (ib_load)      ib_q <= field_in;
      end
   end

   // Outputs decode from state and latched registers only, never from req,
   // so an asynchronous reset drops mem_wren and ack immediately.
   assign busy      = (state != IDLE);
   assign ack       = (state == WR) || (state == RDDONE);
   assign mem_wren  = (state == WR) || ((state == RDDONE) && ai);
   assign mem_raddr = ea;
   assign mem_waddr = ea;
   assign mem_wdata = ((state == RDDONE) && ai) ? rd_inc : wd;

   always_comb begin
      rdata = '0;
      if (state == RDDONE) rdata = ai ? rd_inc : mem_rdata;
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: a behavioural core memory plus a
// scoreboard of expected transaction results popped on each ack.
module tb_mem_sequencer;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0, we = 1'b0, dsel = 1'b0, autoinc_en = 1'b0;
   logic [11:0]   addr = '0, wdata = '0;
   logic          ack, busy;
   logic [11:0]   rdata;
   logic [2:0]    field_in = '0;
   logic          if_load = 1'b0, df_load = 1'b0, ib_load = 1'b0, ib_xfer = 1'b0;
   logic [2:0]    if_q, df_q, ib_q;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic          mem_wren;
   logic [11:0]   mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          is_read;
      logic [11:0]   rdata;
      logic          wren;
      logic [AW-1:0] ea;
      logic [11:0]   wdata;
      int            lat;
   } exp_t;

   exp_t sb[$];

   logic [11:0] mem [0:(1<<AW)-1];

   mem_sequencer #(.AWIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .dsel(dsel),
      .autoinc_en(autoinc_en), .addr(addr), .wdata(wdata), .ack(ack),
      .rdata(rdata), .busy(busy), .field_in(field_in), .if_load(if_load),
      .df_load(df_load), .ib_load(ib_load), .ib_xfer(ib_xfer), .if_q(if_q),
      .df_q(df_q), .ib_q(ib_q), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Core memory with a one-cycle registered read port.
   always @(posedge clk) begin
      if (mem_wren) mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem[mem_raddr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic set_field(input logic il, input logic dl, input logic bl,
                            input logic bx, input logic [2:0] f);
      @(negedge clk);
      if_load = il; df_load = dl; ib_load = bl; ib_xfer = bx; field_in = f;
      @(negedge clk);
      if_load = 1'b0; df_load = 1'b0; ib_load = 1'b0; ib_xfer = 1'b0;
   endtask

   task automatic access(input logic w, input logic d, input logic aie,
                         input logic [11:0] a, input logic [11:0] wd,
                         input logic [11:0] exp_rd, input logic exp_wren,
                         input logic [AW-1:0] exp_ea, input logic [11:0] exp_wd);
      exp_t e;
      exp_t got;
      int   n;
      e.is_read = ~w; e.rdata = exp_rd; e.wren = exp_wren;
      e.ea = exp_ea; e.wdata = exp_wd; e.lat = w ? 1 : 2;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; we = w; dsel = d; autoinc_en = aie; addr = a; wdata = wd;
      @(posedge clk);
      n = 99;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         req = 1'b0;
         if (!w && i == 1) check("raddr_rd", mem_raddr, exp_ea);
         if (ack) begin
            n = i;
            break;
         end
      end
      got = sb.pop_front();
      check("ack_latency", n, got.lat);
      check("busy_at_ack", busy, 1'b1);
      if (got.is_read) check("rdata", rdata, got.rdata);
      check("wren_at_ack", mem_wren, got.wren);
      if (got.wren) begin
         check("waddr", mem_waddr, got.ea);
         check("wdata", mem_wdata, got.wdata);
      end
   endtask

   initial begin
      mem[15'o20012] = 12'o7777;
      mem[15'o20020] = 12'o1111;
      mem[15'o20010] = 12'o2222;
      mem[15'o00010] = 12'o4321;

      // Reset state
      #12;
      check("rst_ack", ack, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wren", mem_wren, 1'b0);
      check("rst_rdata", rdata, 12'o0);
      check("rst_wdata", mem_wdata, 12'o0);
      check("rst_raddr", mem_raddr, 15'o0);
      check("rst_waddr", mem_waddr, 15'o0);
      check("rst_fields", {if_q, df_q, ib_q}, 9'o000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_wren", mem_wren, 1'b0);
      end

      // Write then read in DF=3
      set_field(1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
      check("df_load", df_q, 3'd3);
      access(1'b1, 1'b1, 1'b0, 12'o1234, 12'o5252, 12'o0, 1'b1, 15'o31234, 12'o5252);
      access(1'b0, 1'b1, 1'b0, 12'o1234, 12'o0, 12'o5252, 1'b0, 15'o31234, 12'o0);

      // Auto-index through IF=2, including the 7777 -> 0000 wrap
      set_field(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
      check("if_load", if_q, 3'd2);
      access(1'b0, 1'b0, 1'b1, 12'o0012, 12'o0, 12'o0000, 1'b1, 15'o20012, 12'o0000);
      access(1'b0, 1'b0, 1'b0, 12'o0012, 12'o0, 12'o0000, 1'b0, 15'o20012, 12'o0);

      // Auto-index qualifiers
      access(1'b0, 1'b0, 1'b1, 12'o0020, 12'o0, 12'o1111, 1'b0, 15'o20020, 12'o0);
      access(1'b0, 1'b0, 1'b0, 12'o0010, 12'o0, 12'o2222, 1'b0, 15'o20010, 12'o0);
      access(1'b1, 1'b0, 1'b1, 12'o0010, 12'o3333, 12'o0, 1'b1, 15'o20010, 12'o3333);
      access(1'b0, 1'b0, 1'b0, 12'o0010, 12'o0, 12'o3333, 1'b0, 15'o20010, 12'o0);

      // Field register collisions
      set_field(1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
      set_field(1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
      check("ib_setup", ib_q, 3'd5);
      check("if_setup", if_q, 3'd1);
      set_field(1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
      check("if_beats_xfer", if_q, 3'd4);
      set_field(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
      check("xfer_alone", if_q, 3'd5);
      set_field(1'b0, 1'b0, 1'b1, 1'b1, 3'd6);
      check("xfer_old_ib", if_q, 3'd5);
      check("ib_new", ib_q, 3'd6);
      check("df_kept", df_q, 3'd3);

      // Reset in the middle of a read
      @(negedge clk);
      req = 1'b1; we = 1'b0; dsel = 1'b0; autoinc_en = 1'b0; addr = 12'o0010;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("midrd_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrd_ack", ack, 1'b0);
      check("midrd_idle", busy, 1'b0);
      check("midrd_wren", mem_wren, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ack", ack, 1'b0);
      check("post_rst_if", if_q, 3'd0);
      access(1'b0, 1'b0, 1'b0, 12'o0010, 12'o0, 12'o4321, 1'b0, 15'o00010, 12'o0);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
